// File: rtl/uart_rx.sv
// UART receiver: oversampling-free, mid-bit strobed by an external baud generator.
// Produces one DATA_BITS word per frame with a single-entry output register.
module uart_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 tick,
  output logic                 start_rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 framing_error,
  output logic                 overrun
);

  localparam int CW = $clog2(DATA_BITS) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               state;
  state_t               next_state;
  logic                 rx_meta;
  logic                 rx_sync;
  logic [CW-1:0]        bit_count;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 clear_count;
  logic                 shift_en;
  logic                 accept;
  logic                 bad_stop;

  // Synchronizer flops reset to the idle-high line level so reset never
  // looks like a start edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    next_state  = state;
    start_rx    = 1'b0;
    clear_count = 1'b0;
    shift_en    = 1'b0;
    accept      = 1'b0;
    bad_stop    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_sync && !reset) begin
          start_rx   = 1'b1;
          next_state = START;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_sync) begin
            clear_count = 1'b1;
            next_state  = DATA;
          end else begin
            next_state = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          if (bit_count == LAST_BIT) next_state = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_sync) begin
            accept     = 1'b1;
            next_state = IDLE;
          end else begin
            bad_stop   = 1'b1;
            next_state = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_sync) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Right shift: the first bit received ends up in bit 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_count <= '0;
      shift_reg <= '0;
    end else begin
      if (clear_count)   bit_count <= '0;
      else if (shift_en) bit_count <= bit_count + CW'(1);
      if (shift_en)      shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
      else if (bad_stop) shift_reg <= '0;
    end
  end

  // Single-entry output buffer: an accept coinciding with data_ack replaces
  // the pending word; otherwise a pending word wins and the new one is lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      data          <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= bad_stop;
      if (accept) begin
        if (!data_valid || data_ack) begin
          data       <= shift_reg;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_ack && data_valid) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: behavioural baud generator, directed frame scenarios,
// then randomized frames checked against a single-entry buffer model.
module tb_uart_rx;

  // Scaled-down baud divisor keeps the run short; bit period = DIVISOR + 1.
  localparam int DIVISOR   = 63;
  localparam int BIT       = DIVISOR + 1;
  localparam int HALF      = DIVISOR / 2;
  localparam int GLITCH    = 20;
  localparam int BREAK_LEN = 300;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic       tick;
  logic       start_rx;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ack;
  logic       framing_error;
  logic       overrun;

  int tests       = 0;
  int fails       = 0;
  int start_count = 0;
  int fe_cycles   = 0;
  int baud_cnt    = 0;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_overrun;
  int         m_starts;
  int         m_fe;

  uart_rx #(.DATA_BITS(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .rx            (rx),
    .tick          (tick),
    .start_rx      (start_rx),
    .data          (data),
    .data_valid    (data_valid),
    .data_ack      (data_ack),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 clock = ~clock;

  // Baud generator: restarts its phase on start_rx, strobes mid-bit.
  always @(posedge clock) begin
    if (reset || start_rx || baud_cnt == DIVISOR) baud_cnt <= 0;
    else                                          baud_cnt <= baud_cnt + 1;
  end
  assign tick = (baud_cnt == HALF);

  always @(posedge clock) begin
    if (start_rx)      start_count <= start_count + 1;
    if (framing_error) fe_cycles   <= fe_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One bit period; optionally raises data_ack exactly in the tick cycle.
  task automatic drive_bit(input logic v, input bit ack_on_tick);
    rx = v;
    for (int c = 0; c < BIT; c++) begin
      data_ack = ack_on_tick && tick;
      @(negedge clock);
    end
    data_ack = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit ack_at_stop);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i], 1'b0);
    drive_bit(stop_v, ack_at_stop);
    m_starts++;
  endtask

  task automatic model_accept(input logic [7:0] b, input bit ack);
    if (!m_valid || ack) begin
      m_data  = b;
      m_valid = 1'b1;
    end else begin
      m_overrun = 1'b1;
    end
  endtask

  task automatic ack_pulse();
    data_ack = 1'b1;
    @(negedge clock);
    data_ack = 1'b0;
    @(negedge clock);
    if (m_valid) begin
      m_valid   = 1'b0;
      m_overrun = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_data"},    data,        m_data);
    check({tag, "_valid"},   data_valid,  m_valid);
    check({tag, "_overrun"}, overrun,     m_overrun);
    check({tag, "_starts"},  start_count, m_starts);
    check({tag, "_fe"},      fe_cycles,   m_fe);
  endtask

  initial begin
    logic [7:0] b;
    bit         ack_before;
    bit         ack_stop;
    bit         bad;

    reset     = 1'b1;
    rx        = 1'b1;
    data_ack  = 1'b0;
    m_data    = 8'h00;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
    m_starts  = 0;
    m_fe      = 0;

    idle(5);
    check("rst_start_rx", start_rx, 0);
    check("rst_fe", framing_error, 0);
    check_outputs("rst");
    reset = 1'b0;
    idle(10);

    // Clean frame, held until acknowledged.
    send_frame(8'hA5, 1'b1, 1'b0);
    model_accept(8'hA5, 1'b0);
    idle(3);
    check_outputs("a5");
    idle(50);
    check("a5_hold_valid", data_valid, 1);
    ack_pulse();
    check_outputs("a5_ack");

    // Short low glitch: false start, nothing else changes.
    rx = 1'b0;
    idle(GLITCH);
    rx = 1'b1;
    m_starts++;
    idle(2 * BIT);
    check_outputs("glitch");

    // Bad stop bit followed by a long break.
    send_frame(8'h3C, 1'b0, 1'b0);
    m_fe++;
    idle(BREAK_LEN);
    check("break_starts_low", start_count, m_starts);
    rx = 1'b1;
    idle(2 * BIT);
    check_outputs("break");

    // Two frames without ack: overrun, first word kept.
    send_frame(8'h11, 1'b1, 1'b0);
    model_accept(8'h11, 1'b0);
    idle(2);
    send_frame(8'h22, 1'b1, 1'b0);
    model_accept(8'h22, 1'b0);
    idle(3);
    check_outputs("ovr");
    ack_pulse();
    check_outputs("ovr_ack");

    // Ack landing on the accept cycle replaces the pending word.
    send_frame(8'h11, 1'b1, 1'b0);
    model_accept(8'h11, 1'b0);
    idle(2);
    send_frame(8'h22, 1'b1, 1'b1);
    model_accept(8'h22, 1'b1);
    idle(3);
    check_outputs("ack_same");
    send_frame(8'h99, 1'b1, 1'b0);
    model_accept(8'h99, 1'b0);
    idle(3);
    check_outputs("pre_rst");

    // Reset in the middle of bit 4; remaining bits and stop are high.
    b = 8'hF3;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i], 1'b0);
    m_starts++;
    rx = 1'b1;
    idle(BIT / 2);
    reset = 1'b1;
    @(negedge clock);
    reset     = 1'b0;
    m_data    = 8'h00;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
    check("mid_rst_start_rx", start_rx, 0);
    check("mid_rst_fe", framing_error, 0);
    check_outputs("mid_rst");
    idle(BIT / 2 + 4 * BIT);
    check_outputs("mid_rst_tail");
    send_frame(8'h5A, 1'b1, 1'b0);
    model_accept(8'h5A, 1'b0);
    idle(3);
    check_outputs("after_rst");

    // Randomized frames, acks and stop errors.
    for (int n = 0; n < 12; n++) begin
      b          = 8'($urandom);
      ack_before = ($urandom_range(0, 1) == 1);
      bad        = ($urandom_range(0, 4) == 0);
      ack_stop   = !bad && ($urandom_range(0, 2) == 0);
      if (ack_before) ack_pulse();
      send_frame(b, !bad, ack_stop);
      if (bad) begin
        m_fe++;
        idle(BIT);
        rx = 1'b1;
      end else begin
        model_accept(b, ack_stop);
      end
      idle($urandom_range(3, 12));
      check_outputs($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (format 8N1 at default; LSB first, no parity, one stop bit).
REQ-002 SHALL have port clock  input  1  rising-edge system clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port tick  input  1  mid-bit sample strobe from the baud rate generator.
REQ-006 SHALL have port start_rx  output  1  one-cycle request to the baud rate generator to phase-align to a detected start edge.
REQ-007 SHALL have port data  output  DATA_BITS  last accepted byte.
REQ-008 SHALL have port data_valid  output  1  data holds an unconsumed byte.
REQ-009 SHALL have port data_ack  input  1  consumer takes data; clears data_valid.
REQ-010 SHALL have port framing_error  output  1  one-cycle pulse on bad stop bit.
REQ-011 SHALL have port overrun  output  1  sticky: a frame completed while data_valid was high.

Function
REQ-012 rx SHALL pass through a two-flop synchronizer (rx_sync); all decisions use rx_sync only.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: when rx_sync==0, start_rx SHALL be 1 combinationally that cycle and next state START; start_rx SHALL be 0 in every other state/condition.
REQ-015 tick SHALL be ignored in IDLE and WAIT_HIGH.
REQ-016 START: on tick, rx_sync==0 -> DATA with bit counter cleared; rx_sync==1 -> IDLE (false start, no outputs change).
REQ-017 DATA: on each tick, rx_sync SHALL shift into the shift register MSB position with right shift (first received bit ends in data[0]); after the DATA_BITS-th tick -> STOP.
REQ-018 Bit counter SHALL be $clog2(DATA_BITS)+1 bits wide and SHALL NOT wrap within a frame.
REQ-019 STOP: on tick with rx_sync==1 -> IDLE and byte accepted; rx_sync==0 -> framing_error=1 for exactly that next cycle, shift register discarded, -> WAIT_HIGH.
REQ-020 WAIT_HIGH: remain until rx_sync==1, then -> IDLE (a held-low break SHALL NOT generate repeated frames).
REQ-021 Byte accept with data_valid==0: data<=shift register, data_valid<=1 on the following edge (latency: 1 cycle after stop-bit tick).
REQ-022 Byte accept with data_valid==1 and data_ack==0: data SHALL keep the old byte, overrun<=1, new byte discarded.
REQ-023 Byte accept in the same cycle as data_ack==1: new byte loaded, data_valid stays 1, overrun unchanged.
REQ-024 data_ack with no accept: data_valid<=0 and overrun<=0 next edge; data_ack while data_valid==0 SHALL have no effect.
REQ-025 data SHALL hold its value while data_valid==0 (no change except on accept).
REQ-026 framing_error and overrun SHALL never alter data.

Reset
REQ-027 reset SHALL take priority over all inputs, forcing state IDLE, start_rx=0, data=0, data_valid=0, framing_error=0, overrun=0, counter and shift register 0, synchronizer flops 1.
REQ-028 reset asserted mid-frame SHALL abandon the frame with no data_valid or framing_error pulse; the first frame after reset deasserts SHALL be received normally.

Verification
REQ-029 Bench: baud rate generator instance at 25 MHz / 9600 (divisor 2604, bit period 2605 cycles) drives tick; frames driven at that bit period.
REQ-030 Frame 0xA5, valid stop -> exactly one start_rx pulse, data=0xA5, data_valid=1 until data_ack, no framing_error.
REQ-031 rx low 200 cycles then high (glitch) -> one start_rx pulse, START returns to IDLE, data_valid stays 0, data unchanged.
REQ-032 Frame 0x3C with stop bit 0, rx held low 10000 cycles then high -> one framing_error pulse, data_valid 0, exactly one start_rx total until rx returns high.
REQ-033 Frames 0x11 then 0x22, no ack -> data=0x11, data_valid=1, overrun=1; one data_ack -> data_valid=0, overrun=0.
REQ-034 data_ack asserted the cycle 0x22 is accepted (0x11 pending) -> data=0x22, data_valid=1, overrun=0.
REQ-035 reset pulsed during bit 4 of a frame -> all outputs 0 next cycle; following frame 0x5A -> data=0x5A, data_valid=1.
